// File: rtl/mem_pkg.sv
// Shared memory-subsystem geometry and arbiter state encoding, used by the caches,
// the unified memory and the miss arbiter.
package mem_pkg;
    localparam int ADDR_W  = 16;
    localparam int OFF_W   = 2;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = ADDR_W - OFF_W - TAG_W;
    localparam int LINE_W  = 64;
    localparam int LADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Line-granular main-memory bus: the arbiter is the master, the unified memory the slave.
interface mem_arbiter_if;
    import mem_pkg::*;

    logic [LADDR_W-1:0] mem_addr;
    logic               mem_re;
    logic               mem_we;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_rdy;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata, mem_rdy
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata, mem_rdy
    );
endinterface

// File: rtl/mem_arbiter.sv
// I/D-cache miss arbiter: D first, optional dirty write-back, line fetch, one-cycle fill.
// Optional saturating activity counters are built when ARB_STATS_EN is defined.
module mem_arbiter
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_miss,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic               d_miss,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic               d_victim_dirty,
    input  logic [TAG_W-1:0]   d_victim_tag,
    input  logic [LINE_W-1:0]  d_victim_line,
    mem_arbiter_if.master      bus,
    output logic [LINE_W-1:0]  fill_line,
    output logic [IDX_W-1:0]   fill_idx,
    output logic [TAG_W-1:0]   fill_tag,
    output logic               i_fill_we,
    output logic               d_fill_we
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]        stat_i_fills,
    output logic [15:0]        stat_d_fills,
    output logic [15:0]        stat_writebacks
`endif
);
    arb_state_t         state, state_n;
    logic               grant_d, grant_d_n;
    logic               gap, gap_n;
    logic [LADDR_W-1:0] miss_line, miss_line_n;
    logic [LADDR_W-1:0] mem_addr_n;
    logic [LINE_W-1:0]  mem_wdata_n, fill_line_n;
    logic [IDX_W-1:0]   fill_idx_n;
    logic [TAG_W-1:0]   fill_tag_n;
    logic               mem_re_n, mem_we_n, i_fill_n, d_fill_n;

    logic unused_offsets;
    assign unused_offsets = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        state_n     = state;
        grant_d_n   = grant_d;
        gap_n       = gap;
        miss_line_n = miss_line;
        mem_addr_n  = bus.mem_addr;
        mem_wdata_n = bus.mem_wdata;
        mem_re_n    = 1'b0;
        mem_we_n    = 1'b0;
        fill_line_n = fill_line;
        fill_idx_n  = fill_idx;
        fill_tag_n  = fill_tag;
        i_fill_n    = 1'b0;
        d_fill_n    = 1'b0;
        case (state)
            IDLE: begin
                // The first IDLE after a fill gives the cache time to drop its served miss.
                if (gap) begin
                    gap_n = 1'b0;
                end else if (d_miss) begin
                    grant_d_n   = 1'b1;
                    miss_line_n = d_addr[ADDR_W-1:OFF_W];
                    if (d_victim_dirty) begin
                        state_n     = WB;
                        mem_we_n    = 1'b1;
                        mem_addr_n  = {d_victim_tag, d_addr[OFF_W+IDX_W-1:OFF_W]};
                        mem_wdata_n = d_victim_line;
                    end else begin
                        state_n    = FILL;
                        mem_re_n   = 1'b1;
                        mem_addr_n = d_addr[ADDR_W-1:OFF_W];
                    end
                end else if (i_miss) begin
                    grant_d_n   = 1'b0;
                    miss_line_n = i_addr[ADDR_W-1:OFF_W];
                    state_n     = FILL;
                    mem_re_n    = 1'b1;
                    mem_addr_n  = i_addr[ADDR_W-1:OFF_W];
                end
            end
            WB: begin
                if (bus.mem_rdy) begin
                    state_n    = FILL;
                    mem_re_n   = 1'b1;
                    mem_addr_n = miss_line;
                end else begin
                    mem_we_n = 1'b1;
                end
            end
            FILL: begin
                if (bus.mem_rdy) begin
                    state_n     = DONE;
                    fill_line_n = bus.mem_rdata;
                    fill_idx_n  = miss_line[IDX_W-1:0];
                    fill_tag_n  = miss_line[LADDR_W-1:IDX_W];
                    i_fill_n    = ~grant_d;
                    d_fill_n    = grant_d;
                end else begin
                    mem_re_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                gap_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant_d       <= 1'b0;
            gap           <= 1'b0;
            miss_line     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            fill_line     <= '0;
            fill_idx      <= '0;
            fill_tag      <= '0;
            i_fill_we     <= 1'b0;
            d_fill_we     <= 1'b0;
        end else begin
            state         <= state_n;
            grant_d       <= grant_d_n;
            gap           <= gap_n;
            miss_line     <= miss_line_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
            bus.mem_re    <= mem_re_n;
            bus.mem_we    <= mem_we_n;
            fill_line     <= fill_line_n;
            fill_idx      <= fill_idx_n;
            fill_tag      <= fill_tag_n;
            i_fill_we     <= i_fill_n;
            d_fill_we     <= d_fill_n;
        end
    end

`ifdef ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic wb_done;
    assign wb_done = (state == WB) && bus.mem_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_i_fills    <= '0;
            stat_d_fills    <= '0;
            stat_writebacks <= '0;
        end else begin
            stat_i_fills    <= sat_inc(stat_i_fills, i_fill_we);
            stat_d_fills    <= sat_inc(stat_d_fills, d_fill_we);
            stat_writebacks <= sat_inc(stat_writebacks, wb_done);
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a fixed-latency main-memory model.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_miss, d_miss, d_victim_dirty;
    logic [ADDR_W-1:0]  i_addr, d_addr;
    logic [TAG_W-1:0]   d_victim_tag;
    logic [LINE_W-1:0]  d_victim_line;
    logic [LINE_W-1:0]  fill_line;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               i_fill_we, d_fill_we;
`ifdef ARB_STATS_EN
    logic [15:0]        stat_i_fills, stat_d_fills, stat_writebacks;
`endif

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .d_victim_dirty(d_victim_dirty), .d_victim_tag(d_victim_tag),
        .d_victim_line(d_victim_line),
        .bus(bus),
        .fill_line(fill_line), .fill_idx(fill_idx), .fill_tag(fill_tag),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we)
`ifdef ARB_STATS_EN
        , .stat_i_fills(stat_i_fills), .stat_d_fills(stat_d_fills),
        .stat_writebacks(stat_writebacks)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               we;
        logic [LADDR_W-1:0] addr;
        logic [LINE_W-1:0]  wdata;
    } mem_op_t;

    typedef struct {
        logic               is_d;
        logic [IDX_W-1:0]   idx;
        logic [TAG_W-1:0]   tag;
        logic [LINE_W-1:0]  line;
    } fill_t;

    mem_op_t exp_mem[$];
    fill_t   exp_fill[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, rdy_cyc = -100, req_cnt = 0;
    int fill_seen = 0, we_cycles = 0;
    bit mem_en = 1'b1, force_rdy = 1'b0;
    bit prev_req = 1'b0, prev_rdy = 1'b0, prev_we = 1'b0;
    logic [LADDR_W-1:0] prev_addr = '0;
    logic [LINE_W-1:0]  prev_wdata = '0;

    function automatic logic [LINE_W-1:0] rdata_fn(input logic [LADDR_W-1:0] a);
        return {2'b00, a, 2'b01, ~a, 2'b10, a ^ 14'h2AAA, 2'b11, a + 14'd7};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_miss(input bit is_d, input logic [ADDR_W-1:0] a, input bit dirty,
                               input logic [TAG_W-1:0] vtag, input logic [LINE_W-1:0] vline);
        mem_op_t op;
        fill_t   f;
        if (is_d && dirty) begin
            op.we = 1'b1; op.addr = {vtag, a[OFF_W+IDX_W-1:OFF_W]}; op.wdata = vline;
            exp_mem.push_back(op);
        end
        op.we = 1'b0; op.addr = a[ADDR_W-1:OFF_W]; op.wdata = '0;
        exp_mem.push_back(op);
        f.is_d = is_d; f.idx = a[OFF_W+IDX_W-1:OFF_W]; f.tag = a[ADDR_W-1:ADDR_W-TAG_W];
        f.line = rdata_fn(a[ADDR_W-1:OFF_W]);
        exp_fill.push_back(f);
    endtask

    // One clock: sample just after the edge, check the fill/bus monitor, then run memory.
    task automatic tick();
        fill_t   f;
        mem_op_t op;
        bit      cur_rdy;
        @(posedge clk);
        #1;
        cyc++;
        check("re_we_exclusive", {63'd0, bus.mem_re & bus.mem_we}, 64'd0);
        if (prev_req && !prev_rdy && (bus.mem_re || bus.mem_we)) begin
            check("addr_stable", {50'd0, bus.mem_addr}, {50'd0, prev_addr});
            if (prev_we && bus.mem_we) check("wdata_stable", bus.mem_wdata, prev_wdata);
        end
        if (bus.mem_we) we_cycles++;
        if (i_fill_we || d_fill_we) begin
            fill_seen++;
            check("one_fill_strobe", {63'd0, i_fill_we & d_fill_we}, 64'd0);
            check("fill_expected", {63'd0, exp_fill.size() != 0}, 64'd1);
            if (exp_fill.size() != 0) begin
                f = exp_fill.pop_front();
                check("fill_is_d", {63'd0, d_fill_we}, {63'd0, f.is_d});
                check("fill_idx", {58'd0, fill_idx}, {58'd0, f.idx});
                check("fill_tag", {56'd0, fill_tag}, {56'd0, f.tag});
                check("fill_line", fill_line, f.line);
                check("fill_latency", 64'(cyc), 64'(rdy_cyc + 1));
            end
        end
        cur_rdy = 1'b0;
        if (!mem_en) req_cnt = 0;
        else if (bus.mem_re || bus.mem_we) req_cnt++;
        else req_cnt = 0;
        if (req_cnt == 4) begin
            req_cnt = 0;
            cur_rdy = 1'b1;
            if (bus.mem_re) rdy_cyc = cyc;
            check("mem_op_expected", {63'd0, exp_mem.size() != 0}, 64'd1);
            if (exp_mem.size() != 0) begin
                op = exp_mem.pop_front();
                check("mem_op_we", {63'd0, bus.mem_we}, {63'd0, op.we});
                check("mem_op_re", {63'd0, bus.mem_re}, {63'd0, ~op.we});
                check("mem_op_addr", {50'd0, bus.mem_addr}, {50'd0, op.addr});
                if (op.we) check("mem_op_wdata", bus.mem_wdata, op.wdata);
            end
        end
        bus.mem_rdy   = cur_rdy | force_rdy;
        bus.mem_rdata = rdata_fn(bus.mem_addr);
        prev_req   = bus.mem_re | bus.mem_we;
        prev_we    = bus.mem_we;
        prev_rdy   = bus.mem_rdy;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
    endtask

    task automatic wait_fill(input bit is_d);
        bit got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (is_d ? d_fill_we : i_fill_we) begin
                got = 1'b1;
                break;
            end
        end
        check(is_d ? "d_fill_arrives" : "i_fill_arrives", {63'd0, got}, 64'd1);
    endtask

    initial begin
        int base;
        bit got;
        rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_victim_dirty = 1'b0;
        i_addr = '0; d_addr = '0; d_victim_tag = '0; d_victim_line = '0;
        bus.mem_rdy = 1'b0; bus.mem_rdata = '0;
        repeat (3) tick();
        check("rst_mem_re", {63'd0, bus.mem_re}, 64'd0);
        check("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
        check("rst_mem_addr", {50'd0, bus.mem_addr}, 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        check("rst_fill_line", fill_line, 64'd0);
        check("rst_fill_idx_tag", {50'd0, fill_tag, fill_idx}, 64'd0);
        check("rst_fill_we", {62'd0, i_fill_we, d_fill_we}, 64'd0);
        rst = 1'b0;
        tick();

        // Scenario 1: clean I miss.
        i_addr = 16'h1234; i_miss = 1'b1;
        expect_miss(1'b0, 16'h1234, 1'b0, '0, '0);
        tick();
        check("t1_re_next_cycle", {63'd0, bus.mem_re}, 64'd1);
        check("t1_addr", {50'd0, bus.mem_addr}, 64'h048D);
        wait_fill(1'b0);
        check("t1_idx", {58'd0, fill_idx}, 64'h0D);
        check("t1_tag", {56'd0, fill_tag}, 64'h12);
        i_miss = 1'b0;
        repeat (3) tick();

        // Scenario 2: D miss with dirty victim.
        d_addr = 16'h5678; d_miss = 1'b1; d_victim_dirty = 1'b1;
        d_victim_tag = 8'hAB; d_victim_line = 64'hDEAD_BEEF_0000_1111;
        expect_miss(1'b1, 16'h5678, 1'b1, 8'hAB, 64'hDEAD_BEEF_0000_1111);
        tick();
        check("t2_we_first", {62'd0, bus.mem_we, bus.mem_re}, 64'd2);
        check("t2_wb_addr", {50'd0, bus.mem_addr}, {50'd0, 8'hAB, 6'h1E});
        check("t2_wb_data", bus.mem_wdata, 64'hDEAD_BEEF_0000_1111);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.mem_re) begin got = 1'b1; break; end
        end
        check("t2_read_follows", {63'd0, got}, 64'd1);
        check("t2_rd_addr", {50'd0, bus.mem_addr}, 64'h159E);
        wait_fill(1'b1);
        d_miss = 1'b0; d_victim_dirty = 1'b0;
        repeat (3) tick();

        // Scenario 3: simultaneous misses, D served first, I after the gap.
        d_addr = 16'h3F10; i_addr = 16'hC0DE; d_miss = 1'b1; i_miss = 1'b1;
        expect_miss(1'b1, 16'h3F10, 1'b0, '0, '0);
        expect_miss(1'b0, 16'hC0DE, 1'b0, '0, '0);
        wait_fill(1'b1);
        d_miss = 1'b0;
        tick();
        check("t3_gap_cycle1", {63'd0, bus.mem_re}, 64'd0);
        tick();
        check("t3_gap_cycle2", {63'd0, bus.mem_re}, 64'd0);
        tick();
        check("t3_i_granted", {63'd0, bus.mem_re}, 64'd1);
        check("t3_i_addr", {50'd0, bus.mem_addr}, 64'h3037);
        wait_fill(1'b0);
        i_miss = 1'b0;
        repeat (3) tick();
`ifdef ARB_STATS_EN
        check("stat_i_fills", {48'd0, stat_i_fills}, 64'd2);
        check("stat_d_fills", {48'd0, stat_d_fills}, 64'd2);
        check("stat_writebacks", {48'd0, stat_writebacks}, 64'd1);
`endif

        // Scenario 4: reset during FILL, then a stray late mem_rdy.
        i_addr = 16'h7777; i_miss = 1'b1;
        expect_miss(1'b0, 16'h7777, 1'b0, '0, '0);
        tick();
        check("t4_in_fill", {63'd0, bus.mem_re}, 64'd1);
        mem_en = 1'b0;
        repeat (2) tick();
        rst = 1'b1; i_miss = 1'b0;
        tick();
        check("t4_rst_re", {63'd0, bus.mem_re}, 64'd0);
        check("t4_rst_addr", {50'd0, bus.mem_addr}, 64'd0);
        check("t4_rst_no_fill", {62'd0, i_fill_we, d_fill_we}, 64'd0);
        rst = 1'b0;
        exp_mem.delete();
        exp_fill.delete();
        mem_en = 1'b1;
        base = fill_seen;
        tick();
        force_rdy = 1'b1;
        tick();
        force_rdy = 1'b0;
        repeat (8) tick();
        check("t4_late_rdy_no_fill", 64'(fill_seen - base), 64'd0);
        check("t4_idle_bus", {62'd0, bus.mem_re, bus.mem_we}, 64'd0);

        // Scenario 5: clean D miss never writes.
        base = we_cycles;
        d_addr = 16'h9A4C; d_miss = 1'b1; d_victim_dirty = 1'b0;
        d_victim_tag = 8'h55; d_victim_line = 64'h0123_4567_89AB_CDEF;
        expect_miss(1'b1, 16'h9A4C, 1'b0, 8'h55, 64'h0123_4567_89AB_CDEF);
        tick();
        check("t5_read_direct", {62'd0, bus.mem_we, bus.mem_re}, 64'd1);
        wait_fill(1'b1);
        d_miss = 1'b0;
        repeat (3) tick();
        check("t5_no_writeback", 64'(we_cycles - base), 64'd0);

        check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        check("fill_queue_drained", 64'(exp_fill.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
